// File: rtl/sobel_window_buffer.sv
// sobel_window_buffer
// Streaming 3x3 intensity-window generator placed in front of the Sobel
// edge stage. Pixels arrive in raster order as 24-bit RRGGBB. Each pixel is
// reduced to an 8-bit intensity. Two line buffers keep the previous two rows.
// One registered window is emitted for every interior centre pixel.
//
// Build option: define WINDOW_LUMA_EN to use the luma weighting
// (77R + 150G + 29B) >> 8 for the intensity. By default the intensity is the
// red channel, which matches the red-channel Sobel arithmetic downstream.
module sobel_window_buffer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 426
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_pixel,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] win_data,
  output logic [15:0] win_x,
  output logic [15:0] win_y,
  output logic        win_last,
  output logic        frame_done
);

  localparam int COL_AW = $clog2(IMG_W);
  localparam int ROW_AW = $clog2(IMG_H);
  localparam logic [COL_AW-1:0] COL_LAST = COL_AW'(IMG_W - 1);
  localparam logic [ROW_AW-1:0] ROW_LAST = ROW_AW'(IMG_H - 1);
  localparam logic [COL_AW-1:0] COL_TWO  = COL_AW'(2);
  localparam logic [ROW_AW-1:0] ROW_TWO  = ROW_AW'(2);

  // Raster position of the next pixel to be accepted
  logic [COL_AW-1:0] col_q, col_d;
  logic [ROW_AW-1:0] row_q, row_d;

  // Line buffers: lb_a holds row-2, lb_b holds row-1 (contents never reset)
  logic [7:0] lb_a_q [IMG_W];
  logic [7:0] lb_b_q [IMG_W];

  // Previous two window columns, each packed as {top, middle, bottom}.
  // wl_q becomes the left column and wc_q the centre column of the next window.
  logic [23:0] wl_q;
  logic [23:0] wc_q;

  // Registered window outputs
  logic        win_valid_q, win_valid_d;
  logic [71:0] win_data_q, win_data_d;
  logic [15:0] win_x_q, win_x_d;
  logic [15:0] win_y_q, win_y_d;
  logic        win_last_q, win_last_d;
  logic        frame_done_q, frame_done_d;

  logic        accept;
  logic        col_end;
  logic        row_end;
  logic        load;
  logic [7:0]  intensity;
  logic [23:0] right_col;

`ifdef WINDOW_LUMA_EN
  // Luma weights sum to 256, so the 16-bit sum never overflows and the
  // shifted result always fits in 8 bits.
  function automatic logic [7:0] luma8(input logic [23:0] px);
    logic [15:0] sum;
    sum = 16'(px[23:16]) * 16'd77
        + 16'(px[15:8])  * 16'd150
        + 16'(px[7:0])   * 16'd29;
    return 8'(sum >> 8);
  endfunction

  assign intensity = luma8(in_pixel);
`else
  // Green and blue are not needed when the red channel is the intensity.
  logic unused_gb;
  assign unused_gb = ^in_pixel[15:0];
  assign intensity = in_pixel[23:16];
`endif

  // Input is accepted whenever the output slot is empty or being drained.
  // A pixel presented during reset is never taken.
  assign in_ready = !win_valid_q || win_ready;
  assign accept   = in_valid && in_ready && !reset;

  assign col_end  = (col_q == COL_LAST);
  assign row_end  = (row_q == ROW_LAST);
  assign load     = accept && (col_q >= COL_TWO) && (row_q >= ROW_TWO);

  // Incoming right-hand column: two rows up, one row up, current pixel
  assign right_col = {lb_a_q[col_q], lb_b_q[col_q], intensity};

  // Next-state logic for counters, output handshake and window load
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_valid_d  = win_valid_q;
    win_data_d   = win_data_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    win_last_d   = win_last_q;
    frame_done_d = 1'b0;

    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
    end

    if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_AW'(1);
      end else begin
        col_d = col_q + COL_AW'(1);
      end
      frame_done_d = col_end && row_end;
    end

    if (load) begin
      win_valid_d = 1'b1;
      win_data_d  = {wl_q[23:16], wc_q[23:16], right_col[23:16],
                     wl_q[15:8],  wc_q[15:8],  right_col[15:8],
                     wl_q[7:0],   wc_q[7:0],   right_col[7:0]};
      win_x_d     = 16'(col_q - COL_AW'(1));
      win_y_d     = 16'(row_q - ROW_AW'(1));
      win_last_d  = col_end && row_end;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffer rotation and window column shift on every accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a_q[col_q] <= lb_b_q[col_q];
      lb_b_q[col_q] <= intensity;
      wl_q          <= wc_q;
      wc_q          <= right_col;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_data   = win_data_q;
  assign win_x      = win_x_q;
  assign win_y      = win_y_q;
  assign win_last   = win_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Testbench for sobel_window_buffer on a 5x4 frame. Expected windows come
// from a frame-level model that forms every interior 3x3 neighbourhood
// directly from a stored pixel array.
module tb_sobel_window_buffer;

  localparam int W    = 5;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int NWIN = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic [15:0] win_x;
  logic [15:0] win_y;
  logic        win_last;
  logic        frame_done;

  sobel_window_buffer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_x      (win_x),
    .win_y      (win_y),
    .win_last   (win_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] data;
    logic [15:0] x;
    logic [15:0] y;
    logic        last;
  } win_t;

  typedef struct packed {
    logic [23:0] px;
    logic [7:0]  exp_int;
  } tv_t;

  localparam logic [71:0] FIRST_WIN = 72'h00_01_02_05_06_07_0A_0B_0C;
  localparam logic [71:0] LAST_WIN  = 72'h07_08_09_0C_0D_0E_11_12_13;
  localparam logic [71:0] B2B_WIN   = 72'h64_65_66_69_6A_6B_6E_6F_70;

  win_t        got_q[$];
  win_t        exp_q[$];
  logic [23:0] frm [NPIX];
  int          n_pass   = 0;
  int          n_total  = 0;
  int          fd_count = 0;
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Intensity rule applied to a single pixel
  function automatic logic [7:0] ref_int(input logic [23:0] p);
`ifdef WINDOW_LUMA_EN
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
    return 8'(s / 256);
`else
    return p[23:16];
`endif
  endfunction

  // Every interior centre of the stored frame, in raster order
  task automatic add_expected();
    for (int y = 1; y <= H - 2; y++) begin
      for (int x = 1; x <= W - 2; x++) begin
        win_t w;
        w.data = '0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            w.data = {w.data[63:0], ref_int(frm[(y + dy) * W + x + dx])};
        w.x    = 16'(x);
        w.y    = 16'(y);
        w.last = (x == W - 2) && (y == H - 2);
        exp_q.push_back(w);
      end
    end
  endtask

  // Monitor: record each window transfer and each frame_done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && win_valid && win_ready)
        got_q.push_back({win_data, win_x, win_y, win_last});
      if (!reset && frame_done) fd_count++;
    end
  end

  // Random downstream back-pressure when enabled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) win_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] px, input bit gaps);
    int guard;
    if (gaps) repeat ($urandom_range(0, 1)) tick();
    in_valid = 1'b1;
    in_pixel = px;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL push_timeout: in_ready=%0b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < NPIX; i++) push(frm[i], gaps);
  endtask

  task automatic fill_raster(input int base);
    for (int i = 0; i < NPIX; i++) frm[i] = {3{8'(base + i)}};
  endtask

  task automatic start();
    got_q.delete();
    exp_q.delete();
    fd_count = 0;
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    win_ready  = 1'b1;
    repeat (4) tick();
  endtask

  task automatic compare_all(input string tag);
    int n;
    check({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_win%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
  endtask

  initial begin
    tv_t  tbl [4];
    win_t w;

`ifdef WINDOW_LUMA_EN
    tbl[0] = '{px: 24'hFFFFFF, exp_int: 8'd255};
    tbl[1] = '{px: 24'h00FF00, exp_int: 8'd149};
    tbl[2] = '{px: 24'h0000FF, exp_int: 8'd28};
    tbl[3] = '{px: 24'h7F0000, exp_int: 8'd38};
`else
    tbl[0] = '{px: 24'hFFFFFF, exp_int: 8'd255};
    tbl[1] = '{px: 24'h00FF00, exp_int: 8'd0};
    tbl[2] = '{px: 24'h7F0000, exp_int: 8'd127};
    tbl[3] = '{px: 24'h0000FF, exp_int: 8'd0};
`endif

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_pixel  = '0;
    win_ready = 1'b1;
    tick();
    tick();

    // Reset state
    @(negedge clk);
    check("rst_win_valid",  128'(win_valid),  128'(0));
    check("rst_win_data",   128'(win_data),   128'(0));
    check("rst_win_x",      128'(win_x),      128'(0));
    check("rst_win_y",      128'(win_y),      128'(0));
    check("rst_win_last",   128'(win_last),   128'(0));
    check("rst_frame_done", 128'(frame_done), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1));
    tick();

    // Raster frame, downstream always ready
    start();
    fill_raster(0);
    add_expected();
    send_frame(1'b0);
    drain();
    compare_all("basic");
    check("basic_frame_done", 128'(fd_count), 128'(1));
    w = (got_q.size() > 0) ? got_q[0] : '0;
    check("basic_first_data", 128'(w.data), 128'(FIRST_WIN));
    check("basic_first_xy",   128'({w.x, w.y}), 128'({16'd1, 16'd1}));
    w = (got_q.size() > 0) ? got_q[got_q.size() - 1] : '0;
    check("basic_last_data", 128'(w.data), 128'(LAST_WIN));
    check("basic_last_xyl",  128'({w.x, w.y, w.last}), 128'({16'd3, 16'd2, 1'b1}));

    // Downstream stall right after the first window
    start();
    fill_raster(0);
    add_expected();
    for (int i = 0; i < 12; i++) push(frm[i], 1'b0);
    win_ready = 1'b0;
    push(frm[12], 1'b0);
    in_valid = 1'b1;
    in_pixel = frm[13];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready_c%0d", c),  128'(in_ready),  128'(0));
      check($sformatf("stall_win_valid_c%0d", c), 128'(win_valid), 128'(1));
      check($sformatf("stall_win_data_c%0d", c),  128'(win_data),  128'(FIRST_WIN));
      @(posedge clk);
      #1;
    end
    win_ready = 1'b1;
    for (int i = 13; i < NPIX; i++) push(frm[i], 1'b0);
    drain();
    compare_all("stall");
    check("stall_frame_done", 128'(fd_count), 128'(1));

    // Input gaps and random back-pressure on the raster frame
    start();
    fill_raster(0);
    add_expected();
    rand_ready = 1'b1;
    send_frame(1'b1);
    drain();
    compare_all("gaps");
    check("gaps_frame_done", 128'(fd_count), 128'(1));

    // Random pixel content with gaps and back-pressure
    for (int f = 0; f < 3; f++) begin
      start();
      for (int i = 0; i < NPIX; i++) frm[i] = 24'($urandom);
      add_expected();
      rand_ready = 1'b1;
      send_frame(1'b1);
      drain();
      compare_all($sformatf("rand%0d", f));
      check($sformatf("rand%0d_frame_done", f), 128'(fd_count), 128'(1));
    end

    // Uniform frames: every window element equals the tabled intensity
    for (int t = 0; t < 4; t++) begin
      start();
      for (int i = 0; i < NPIX; i++) frm[i] = tbl[t].px;
      send_frame(1'b0);
      drain();
      check($sformatf("uni%0d_count", t), 128'(got_q.size()), 128'(NWIN));
      for (int i = 0; i < got_q.size(); i++)
        check($sformatf("uni%0d_win%0d", t, i), 128'(got_q[i].data), 128'({9{tbl[t].exp_int}}));
    end

    // Reset mid-frame after accepting (3,2), with a pixel offered during reset
    start();
    fill_raster(0);
    for (int i = 0; i <= 13; i++) push(frm[i], 1'b0);
    in_valid = 1'b1;
    in_pixel = 24'hAAAAAA;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_win_valid", 128'(win_valid), 128'(0));
    check("midrst_in_ready",  128'(in_ready),  128'(1));
    @(posedge clk);
    #1;
    start();
    add_expected();
    send_frame(1'b0);
    drain();
    compare_all("midrst");
    check("midrst_frame_done", 128'(fd_count), 128'(1));

    // Two back-to-back frames
    start();
    fill_raster(0);
    add_expected();
    send_frame(1'b0);
    fill_raster(100);
    add_expected();
    send_frame(1'b0);
    drain();
    compare_all("b2b");
    check("b2b_frame_done", 128'(fd_count), 128'(2));
    w = (got_q.size() > NWIN) ? got_q[NWIN] : '0;
    check("b2b_second_first", 128'(w.data), 128'(B2B_WIN));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sobel_window_buffer.md
# sobel_window_buffer

Streaming 3x3 neighbourhood generator that sits directly upstream of the Sobel edge-detection stage. It accepts 24-bit RRGGBB pixels in raster order, reduces each pixel to an 8-bit intensity, and stores the two previous image rows in line buffers. For every interior pixel it emits one registered 3x3 intensity window plus the centre coordinates, so the edge stage no longer needs whole-frame random-access memory.

## Interface
- IMG_W, 640, image width in pixels (>= 3)
- IMG_H, 426, image height in pixels (>= 3)
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_pixel is valid
- in_ready  output  1  block accepts in_pixel this cycle
- in_pixel  input  24  RRGGBB pixel, raster order, frame starts at (0,0)
- win_valid  output  1  window outputs valid
- win_ready  input  1  downstream accepts window this cycle
- win_data  output  72  3x3 window, 8 bits per element; [71:64] top_left, [63:56] top, [55:48] top_right, [47:40] left, [39:32] centre, [31:24] right, [23:16] bottom_left, [15:8] bottom, [7:0] bottom_right
- win_x  output  16  centre column (1..IMG_W-2)
- win_y  output  16  centre row (1..IMG_H-2)
- win_last  output  1  window is the last of the frame, centre (IMG_W-2, IMG_H-2)
- frame_done  output  1  one-cycle pulse after the final pixel of a frame is accepted

## Operation
- Intensity: 8-bit value derived from in_pixel (see Configuration). It is computed combinationally in the accept cycle.
- Accept occurs when in_valid && in_ready. in_ready = !win_valid || win_ready, combinational.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accept. col wraps to 0 and increments row. At (IMG_W-1, IMG_H-1) both wrap to 0.
- Line buffers: lb_a holds row-2 and lb_b holds row-1, each IMG_W x 8 bits, read asynchronously at index col.
- On accept:
  - Window column registers shift left.
  - The new right column becomes {lb_a[col], lb_b[col], intensity}.
  - Write lb_a[col] <= lb_b[col] and lb_b[col] <= intensity.
- Window load: if col >= 2 and row >= 2 on accept, register the shifted 3x3 window into win_data and set win_x = col-1, win_y = row-1. Set win_valid = 1 and win_last = (col==IMG_W-1 && row==IMG_H-1).
- Window columns are not cleared at row start. Stale columns at col 0/1 are never emitted.
- Output handshake: win_valid clears on win_ready unless a new window loads in the same cycle. win_data, win_x, win_y and win_last stay stable while win_valid && !win_ready.
- Windows per frame: (IMG_W-2)*(IMG_H-2). With the defaults this is 638*424 = 270512.
- No state carries across frames. The first two rows of each frame overwrite the line buffers before use.

## Timing
- Reset values:
  - win_valid 0, win_data 0, win_x 0, win_y 0, win_last 0, frame_done 0.
  - col 0, row 0.
  - in_ready is 1 in the cycle after reset.
- Line buffer contents are not cleared by reset.
- Latency: window outputs become valid on the rising edge that accepts the pixel completing the window (registered; 1 cycle after input presentation).
- Throughput: 1 pixel/cycle with win_ready held high.
- frame_done asserts for exactly 1 cycle, on the edge that accepts pixel (IMG_W-1, IMG_H-1), coincident with win_valid/win_last of the last window.
- Reset mid-frame: the next accepted pixel is (0,0). Any pending window is dropped and no window is emitted until col,row >= 2 again.
- Reset asserted together with in_valid: the pixel is not accepted.

## Configuration
- WINDOW_LUMA_EN defined:
  - intensity = (77*R + 150*G + 29*B) >> 8, computed with an unsigned 16-bit sum; the result range is 0..255.
- WINDOW_LUMA_EN undefined:
  - intensity = R, i.e. in_pixel[23:16]. This matches the red-channel Sobel arithmetic downstream.

## Test plan
- IMG_W=5, IMG_H=4, in_pixel R = raster index, win_ready=1, no macro:
  - exactly 6 windows are emitted;
  - the first has centre (1,1) and win_data elements 0,1,2,5,6,7,10,11,12;
  - the last has centre (3,2), win_last=1 and elements 7,8,9,12,13,14,17,18,19; frame_done pulses once.
- Same frame with win_ready=0 for 10 cycles after the first window:
  - in_ready=0 throughout and win_data holds 0,1,2,5,6,7,10,11,12;
  - after release, the window sequence is identical to the first scenario and no pixel is lost.
- Random in_valid gaps (~50% duty) and random win_ready, on the same frame:
  - the emitted window sequence is identical to the first scenario.
- WINDOW_LUMA_EN defined:
  - a uniform frame of FFFFFF gives all elements 255;
  - 00FF00 gives 149;
  - 0000FF gives 28.
- Without the macro:
  - 00FF00 gives 0;
  - 7F0000 gives 127.
- Reset asserted after accepting (3,2) in the 5x4 frame, then a full new frame:
  - win_valid=0 the cycle after reset;
  - the next 6 windows match the first scenario exactly.
- Two back-to-back 5x4 frames, the second using R = 100 + index:
  - the second frame's first window is 100,101,102,105,106,107,110,111,112 (no first-frame data);
  - frame_done pulses twice.
